// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding select
// codes, controller state encoding, the zero-register index and a helper
// that picks a forwarding source for one EX operand.
package pipe_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    HZ_RUN    = 1'b0,
    HZ_MDWAIT = 1'b1
  } hz_state_t;

  // Youngest producer wins: EX/MEM beats MEM/WB; r0 is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic [4:0] wa_mem,
    input logic       wrf_mem,
    input logic [4:0] wa_wb,
    input logic       wrf_wb
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (wrf_mem && (wa_mem != REG_ZERO) && (wa_mem == src)) begin
      sel = FWD_MEM;
    end else if (wrf_wb && (wa_wb != REG_ZERO) && (wa_wb == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of pipeline-state inputs and stall/flush/forward controls exchanged
// between the datapath (master) and the hazard controller (slave).
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);

  logic [4:0]       rs_id;
  logic [4:0]       rt_id;
  logic             use_rs_id;
  logic             use_rt_id;
  logic [4:0]       rs_ex;
  logic [4:0]       rt_ex;
  logic [4:0]       wa_ex;
  logic             wrf_ex;
  logic             wdc_ex;
  logic             md_start_ex;
  logic             br_taken_ex;
  logic [4:0]       wa_mem;
  logic             wrf_mem;
  logic [4:0]       wa_wb;
  logic             wrf_wb;

  logic             stall_pc;
  logic             stall_ifid;
  logic             stall_idex;
  logic             flush_ifid;
  logic             flush_idex;
  logic             flush_exmem;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             md_busy;
  logic [CNT_W-1:0] stall_cnt;

  // Datapath side: publishes stage contents, consumes controls.
  modport master (
    output rs_id, rt_id, use_rs_id, use_rt_id, rs_ex, rt_ex,
           wa_ex, wrf_ex, wdc_ex, md_start_ex, br_taken_ex,
           wa_mem, wrf_mem, wa_wb, wrf_wb,
    input  stall_pc, stall_ifid, stall_idex, flush_ifid, flush_idex,
           flush_exmem, fwd_a, fwd_b, md_busy, stall_cnt
  );

  // Controller side.
  modport slave (
    input  rs_id, rt_id, use_rs_id, use_rt_id, rs_ex, rt_ex,
           wa_ex, wrf_ex, wdc_ex, md_start_ex, br_taken_ex,
           wa_mem, wrf_mem, wa_wb, wrf_wb,
    output stall_pc, stall_ifid, stall_idex, flush_ifid, flush_idex,
           flush_exmem, fwd_a, fwd_b, md_busy, stall_cnt
  );

endinterface

// File: rtl/fwd_unit.sv
// Combinational forwarding selects for both EX operands. When en is low
// (reset) both selects fall back to the register file.
module fwd_unit
  import pipe_pkg::*;
(
  input  logic       en,
  input  logic [4:0] rs_ex,
  input  logic [4:0] rt_ex,
  input  logic [4:0] wa_mem,
  input  logic       wrf_mem,
  input  logic [4:0] wa_wb,
  input  logic       wrf_wb,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  logic [4:0] src [2];
  logic [1:0] sel [2];

  assign src[0] = rs_ex;
  assign src[1] = rt_ex;

  // Identical compare network per operand.
  for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
    always_comb begin
      sel[gi] = FWD_RF;
      if (en) begin
        sel[gi] = fwd_sel(src[gi], wa_mem, wrf_mem, wa_wb, wrf_wb);
      end
    end
  end

  assign fwd_a = sel[0];
  assign fwd_b = sel[1];

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage MIPS pipeline: load-use
// bubble insertion, taken-branch squash, multi-cycle mult/div occupancy of
// EX, operand forwarding and a free-running stall-cycle counter.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 32
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave hz
);

  // A mult/div holds EX for MD_LAT-1 extra cycles; md_cnt counts down to 0.
  localparam bit         MD_MULTI = (MD_LAT > 1);
  localparam logic [3:0] MD_LOAD  = MD_MULTI ? 4'(MD_LAT - 2) : 4'd0;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  hz_state_t        state_reg;
  logic [3:0]       md_cnt_reg;
  logic             md_busy_reg;
  logic [CNT_W-1:0] stall_cnt_reg;

  logic load_use;
  logic stall_pc;
  logic stall_ifid;
  logic stall_idex;
  logic flush_ifid;
  logic flush_idex;
  logic flush_exmem;

  // Load in EX whose destination is read by the instruction in ID.
  assign load_use = hz.wrf_ex && hz.wdc_ex && (hz.wa_ex != REG_ZERO) &&
                    ((hz.use_rs_id && (hz.rs_id == hz.wa_ex)) ||
                     (hz.use_rt_id && (hz.rt_id == hz.wa_ex)));

  // Stall/flush decode: mult/div wait dominates, then branch, then load-use.
  always_comb begin
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    stall_idex  = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    if (!rst) begin
      if (state_reg == HZ_MDWAIT) begin
        stall_pc    = 1'b1;
        stall_ifid  = 1'b1;
        stall_idex  = 1'b1;
        flush_exmem = 1'b1;
      end else if (hz.br_taken_ex) begin
        // The dependent instruction is squashed, so no load-use stall.
        flush_ifid = 1'b1;
        flush_idex = 1'b1;
      end else if (load_use) begin
        stall_pc   = 1'b1;
        stall_ifid = 1'b1;
        flush_idex = 1'b1;
      end
    end
  end

  // Mult/div occupancy FSM with registered busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= HZ_RUN;
      md_cnt_reg  <= 4'd0;
      md_busy_reg <= 1'b0;
    end else begin
      case (state_reg)
        HZ_RUN: begin
          if (hz.md_start_ex && MD_MULTI) begin
            state_reg   <= HZ_MDWAIT;
            md_cnt_reg  <= MD_LOAD;
            md_busy_reg <= 1'b1;
          end
        end
        HZ_MDWAIT: begin
          if (md_cnt_reg == 4'd0) begin
            state_reg   <= HZ_RUN;
            md_busy_reg <= 1'b0;
          end else begin
            md_cnt_reg <= md_cnt_reg - 4'd1;
          end
        end
        default: begin
          state_reg   <= HZ_RUN;
          md_cnt_reg  <= 4'd0;
          md_busy_reg <= 1'b0;
        end
      endcase
    end
  end

  // Count every cycle the PC is held; wraps naturally at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= '0;
    end else if (stall_pc) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_ONE;
    end
  end

  fwd_unit u_fwd (
    .en      (!rst),
    .rs_ex   (hz.rs_ex),
    .rt_ex   (hz.rt_ex),
    .wa_mem  (hz.wa_mem),
    .wrf_mem (hz.wrf_mem),
    .wa_wb   (hz.wa_wb),
    .wrf_wb  (hz.wrf_wb),
    .fwd_a   (hz.fwd_a),
    .fwd_b   (hz.fwd_b)
  );

  assign hz.stall_pc    = stall_pc;
  assign hz.stall_ifid  = stall_ifid;
  assign hz.stall_idex  = stall_idex;
  assign hz.flush_ifid  = flush_ifid;
  assign hz.flush_idex  = flush_idex;
  assign hz.flush_exmem = flush_exmem;
  assign hz.md_busy     = md_busy_reg && !rst;
  assign hz.stall_cnt   = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. Two instances share one stimulus:
// MD_LAT=4 with a 32-bit counter, and MD_LAT=1 with a 2-bit counter so
// that counter wrap is visible. A behavioural model is checked every cycle
// and directed literal checks pin the model.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [4:0] rs_id, rt_id, rs_ex, rt_ex, wa_ex, wa_mem, wa_wb;
  logic       use_rs_id, use_rt_id, wrf_ex, wdc_ex, md_start_ex, br_taken_ex;
  logic       wrf_mem, wrf_wb;

  hazard_ctrl_if #(.CNT_W(32)) bus4 ();
  hazard_ctrl_if #(.CNT_W(2))  bus1 ();

  always_comb begin
    bus4.rs_id = rs_id;           bus1.rs_id = rs_id;
    bus4.rt_id = rt_id;           bus1.rt_id = rt_id;
    bus4.use_rs_id = use_rs_id;   bus1.use_rs_id = use_rs_id;
    bus4.use_rt_id = use_rt_id;   bus1.use_rt_id = use_rt_id;
    bus4.rs_ex = rs_ex;           bus1.rs_ex = rs_ex;
    bus4.rt_ex = rt_ex;           bus1.rt_ex = rt_ex;
    bus4.wa_ex = wa_ex;           bus1.wa_ex = wa_ex;
    bus4.wrf_ex = wrf_ex;         bus1.wrf_ex = wrf_ex;
    bus4.wdc_ex = wdc_ex;         bus1.wdc_ex = wdc_ex;
    bus4.md_start_ex = md_start_ex; bus1.md_start_ex = md_start_ex;
    bus4.br_taken_ex = br_taken_ex; bus1.br_taken_ex = br_taken_ex;
    bus4.wa_mem = wa_mem;         bus1.wa_mem = wa_mem;
    bus4.wrf_mem = wrf_mem;       bus1.wrf_mem = wrf_mem;
    bus4.wa_wb = wa_wb;           bus1.wa_wb = wa_wb;
    bus4.wrf_wb = wrf_wb;         bus1.wrf_wb = wrf_wb;
  end

  hazard_ctrl #(.MD_LAT(4), .CNT_W(32)) dut4 (.clk(clk), .rst(rst), .hz(bus4.slave));
  hazard_ctrl #(.MD_LAT(1), .CNT_W(2))  dut1 (.clk(clk), .rst(rst), .hz(bus1.slave));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int     lat [2] = '{4, 1};
  longint cmax[2] = '{64'hFFFF_FFFF, 64'd3};
  int     left[2];          // stall cycles still owed to a mult/div
  longint cnt [2];
  bit     known = 1'b0;     // model state valid once a reset edge was seen

  function automatic logic [1:0] src_sel(input logic [4:0] src);
    if (wrf_mem && wa_mem != 0 && wa_mem == src) return 2'b01;
    if (wrf_wb && wa_wb != 0 && wa_wb == src) return 2'b10;
    return 2'b00;
  endfunction

  // Per-cycle compare of both instances against the model, then advance it.
  always @(negedge clk) begin
    logic [10:0] obs [2];
    longint      ocnt[2];
    logic        lu, sp, si, sx, fi, fx, fm, mb;
    logic [1:0]  fa, fb;
    obs[0] = {bus4.stall_pc, bus4.stall_ifid, bus4.stall_idex, bus4.flush_ifid,
              bus4.flush_idex, bus4.flush_exmem, bus4.md_busy, bus4.fwd_a, bus4.fwd_b};
    obs[1] = {bus1.stall_pc, bus1.stall_ifid, bus1.stall_idex, bus1.flush_ifid,
              bus1.flush_idex, bus1.flush_exmem, bus1.md_busy, bus1.fwd_a, bus1.fwd_b};
    ocnt[0] = longint'(bus4.stall_cnt);
    ocnt[1] = longint'(bus1.stall_cnt);
    chk("md_br_exclusive", longint'(md_start_ex & br_taken_ex), 0);
    lu = wrf_ex && wdc_ex && wa_ex != 0 &&
         ((use_rs_id && rs_id == wa_ex) || (use_rt_id && rt_id == wa_ex));
    for (int d = 0; d < 2; d++) begin
      {sp, si, sx, fi, fx, fm, mb} = 7'b0;
      fa = 2'b00;
      fb = 2'b00;
      if (!rst) begin
        fa = src_sel(rs_ex);
        fb = src_sel(rt_ex);
        if (known && left[d] > 0) begin
          {sp, si, sx, fm, mb} = 5'b11111;
        end else if (br_taken_ex) begin
          {fi, fx} = 2'b11;
        end else if (lu) begin
          {sp, si, fx} = 3'b111;
        end
      end
      chk($sformatf("ctl_lat%0d", lat[d]), longint'(obs[d]),
          longint'({sp, si, sx, fi, fx, fm, mb, fa, fb}));
      if (!rst && known)
        chk($sformatf("stall_cnt_lat%0d", lat[d]), ocnt[d], cnt[d]);
      if (rst) begin
        left[d] = 0;
        cnt[d]  = 0;
      end else begin
        if (sp) cnt[d] = (cnt[d] == cmax[d]) ? 0 : cnt[d] + 1;
        if (left[d] > 0) left[d] = left[d] - 1;
        else if (md_start_ex && lat[d] > 1) left[d] = lat[d] - 1;
      end
    end
    if (rst) known = 1'b1;
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    {rs_id, rt_id, rs_ex, rt_ex, wa_ex, wa_mem, wa_wb} = '0;
    {use_rs_id, use_rt_id, wrf_ex, wdc_ex, md_start_ex, br_taken_ex} = '0;
    {wrf_mem, wrf_wb} = '0;
  endtask

  task automatic set_lu(input logic [4:0] reg_no, input bit via_rt);
    wa_ex = reg_no; wrf_ex = 1'b1; wdc_ex = 1'b1;
    if (via_rt) begin rt_id = reg_no; use_rt_id = 1'b1; end
    else begin rs_id = reg_no; use_rs_id = 1'b1; end
  endtask

  initial begin
    clear();
    rst = 1'b1;
    md_start_ex = 1'b1;
    wa_mem = 5'd7; wrf_mem = 1'b1; rs_ex = 5'd7;
    // Reset held for two cycles with md_start_ex and a forward match present.
    step(); #2;
    chk("rst_stall_pc", bus4.stall_pc, 0);
    chk("rst_fwd_a", bus4.fwd_a, 0);
    step();
    clear(); rst = 1'b0; #2;
    chk("post_rst_cnt", bus4.stall_cnt, 0);
    chk("post_rst_busy", bus4.md_busy, 0);

    // Load-use on rs: one bubble.
    step(); set_lu(5'd5, 1'b0); #2;
    chk("lu_stall_pc", bus4.stall_pc, 1);
    chk("lu_flush_idex", bus4.flush_idex, 1);
    chk("lu_stall_idex", bus4.stall_idex, 0);
    step(); clear(); #2;
    chk("lu_released", bus4.stall_pc, 0);
    chk("lu_cnt", bus4.stall_cnt, 1);
    // Register 0 never creates a hazard.
    step(); set_lu(5'd0, 1'b0); #2;
    chk("lu_r0_no_stall", bus4.stall_pc, 0);
    // Load-use on rt.
    step(); clear(); set_lu(5'd9, 1'b1); #2;
    chk("lu_rt_stall", bus4.stall_ifid, 1);
    // Two more stalled cycles: counter 4, 2-bit counter wraps to 0.
    step(); #2;
    step(); #2;
    step(); clear(); #2;
    chk("cnt4_after_lu", bus4.stall_cnt, 4);
    chk("cnt_wrap_2bit", bus1.stall_cnt, 0);

    // Forwarding priority.
    step(); wa_mem = 5'd7; wa_wb = 5'd7; rs_ex = 5'd7; wrf_mem = 1'b1; wrf_wb = 1'b1; #2;
    chk("fwd_a_mem", bus4.fwd_a, 1);
    step(); wrf_mem = 1'b0; #2;
    chk("fwd_a_wb", bus4.fwd_a, 2);
    step(); wrf_mem = 1'b1; wa_mem = 5'd0; rt_ex = 5'd0; #2;
    chk("fwd_b_r0", bus4.fwd_b, 0);
    chk("fwd_a_wb_again", bus4.fwd_a, 2);
    step(); rt_ex = 5'd7; #2;
    chk("fwd_b_wb", bus4.fwd_b, 2);

    // Mult/div occupancy.
    step(); clear(); md_start_ex = 1'b1; #2;
    chk("md_start_no_stall", bus4.stall_pc, 0);
    step(); md_start_ex = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      #2;
      chk($sformatf("md_busy_c%0d", k), bus4.md_busy, 1);
      chk($sformatf("md_flush_exmem_c%0d", k), bus4.flush_exmem, 1);
      chk($sformatf("md1_idle_c%0d", k), bus1.stall_pc, 0);
      step();
    end
    #2;
    chk("md_done", bus4.md_busy, 0);
    chk("md_cnt", bus4.stall_cnt, 7);
    chk("md1_cnt", bus1.stall_cnt, 0);

    // Branch beats load-use.
    step(); br_taken_ex = 1'b1; set_lu(5'd3, 1'b0); #2;
    chk("br_flush_ifid", bus4.flush_ifid, 1);
    chk("br_no_stall", bus4.stall_pc, 0);
    step(); clear(); #2;
    chk("br_cnt", bus4.stall_cnt, 7);

    // Reset during the second MD_WAIT cycle.
    step(); md_start_ex = 1'b1;
    step(); md_start_ex = 1'b0; #2;
    chk("mdr_busy_c1", bus4.md_busy, 1);
    step(); rst = 1'b1; #2;
    chk("mdr_busy_in_rst", bus4.md_busy, 0);
    step(); rst = 1'b0; #2;
    chk("mdr_busy_after", bus4.md_busy, 0);
    chk("mdr_stall_after", bus4.stall_pc, 0);
    chk("mdr_cnt", bus4.stall_cnt, 0);
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
